// File: rtl/sample_capture_ctrl.sv
// sample_capture_ctrl: tick-enabled 8-bit sample capture engine.
// Bytes taken from sample_in on every divided tick are packed into 64-bit
// words (byte 0 = first sample in bits [7:0]) and queued in a small output
// FIFO with a valid/ready handshake. A run captures exactly num_words words.
// The run then waits for the FIFO to drain before signalling done.
// abort cancels a run at any time and discards everything queued.
module sample_capture_ctrl #(
    parameter int DIV        = 3333,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                        fastclk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        abort,
    input  logic [CNT_W-1:0]            num_words,
    input  logic [7:0]                  sample_in,
    output logic                        sample_tick,
    output logic [63:0]                 word_data,
    output logic                        word_valid,
    input  logic                        word_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        busy,
    output logic                        done,
    output logic                        overflow
);

    // The divider covers the full legal DIV range (up to 4095) with 12 bits.
    localparam int               AW         = $clog2(FIFO_DEPTH);
    localparam int               DCW        = 12;
    localparam logic [DCW-1:0]   DIV_LAST   = DCW'(DIV - 1);
    localparam logic [DCW-1:0]   DIV_ONE    = DCW'(1);
    localparam logic [AW:0]      FULL_LEVEL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]      LEVEL_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0]    PTR_ONE    = AW'(1);
    localparam logic [CNT_W-1:0] WORDS_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_DRAIN
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [DCW-1:0]   div_cnt;
    logic [2:0]       byte_idx;
    logic [CNT_W-1:0] words_left;
    logic [55:0]      byte_shift;

    logic [63:0]      fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    logic             start_ok;
    logic             tick;
    logic             word_end;
    logic             last_word;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic             drop;
    logic [63:0]      word_assembled;

    // abort outranks start, so an aborted start neither begins a run nor
    // clears the sticky overflow flag.
    assign start_ok  = (state == ST_IDLE) && start && (num_words != '0) && !abort;

    // A tick is the last divider count of a capture period; abort cancels it.
    assign tick      = (state == ST_CAPTURE) && (div_cnt == DIV_LAST) && !abort;
    assign word_end  = tick && (byte_idx == 3'd7);
    assign last_word = word_end && (words_left == WORDS_ONE);

    // A word completing into a full FIFO is only kept if the head leaves on
    // the same edge; otherwise it is dropped but still counts toward the run.
    assign fifo_full = (count == FULL_LEVEL);
    assign pop       = word_valid && word_ready && !abort;
    assign push      = word_end && (!fifo_full || pop);
    assign drop      = word_end && fifo_full && !pop;

    // The eighth byte comes straight from the pins so the word is queued on
    // the same edge that captures it.
    assign word_assembled = {sample_in, byte_shift};

    assign sample_tick = tick && !reset;
    assign word_valid  = (count != '0);
    assign word_data   = word_valid ? fifo_mem[rd_ptr] : '0;
    assign fifo_level  = count;
    assign busy        = (state != ST_IDLE);

    // State register.
    always_ff @(posedge fastclk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection and the single-cycle done pulse out of DRAIN.
    always_comb begin
        state_next = state;
        done       = 1'b0;
        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        state_next = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (last_word) begin
                        state_next = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (count == '0) begin
                        state_next = ST_IDLE;
                        done       = ~reset;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Sample divider: free-runs 0..DIV-1 while capturing, parked at 0 otherwise.
    always_ff @(posedge fastclk) begin
        if (reset || abort || (state != ST_CAPTURE)) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_ONE;
        end
    end

    // Byte packing: bytes shift in from the top so byte 0 ends up in [7:0].
    always_ff @(posedge fastclk) begin
        if (reset || abort || start_ok) begin
            byte_idx   <= '0;
            byte_shift <= '0;
        end else if (tick) begin
            byte_idx   <= byte_idx + 3'd1;
            byte_shift <= {sample_in, byte_shift[55:8]};
        end
    end

    // Remaining-word counter for the current run.
    always_ff @(posedge fastclk) begin
        if (reset || abort) begin
            words_left <= '0;
        end else if (start_ok) begin
            words_left <= num_words;
        end else if (word_end) begin
            words_left <= words_left - WORDS_ONE;
        end
    end

    // FIFO storage; contents need no reset because only occupied slots are read.
    always_ff @(posedge fastclk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= word_assembled;
        end
    end

    // FIFO pointers and occupancy; abort empties the queue outright.
    always_ff @(posedge fastclk) begin
        if (reset || abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + LEVEL_ONE;
                2'b01:   count <= count - LEVEL_ONE;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow flag: cleared by reset or a new run, survives abort.
    always_ff @(posedge fastclk) begin
        if (reset || start_ok) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: doc/sample_capture_ctrl.md
Name: sample_capture_ctrl

Overview:
- Sequences 8-bit parallel sample capture into 64-bit words and hands them downstream.
- Replaces free-running slow-clock sampling with a single-clock, tick-enabled capture engine.
- Provides a start/abort command interface and a word-count target.
- Includes a small output FIFO with valid/ready so a slow consumer does not stall sampling.
- Sits between the 8 digital input pins and the downstream bus consumer (transmitter/memory writer).

Parameters:
- DIV, 3333, fastclk cycles per sample tick (50 MHz / 3333 ≈ 15 kHz); legal range 2..4095.
- FIFO_DEPTH, 4, output word FIFO entries; power of 2, minimum 2.
- CNT_W, 16, width of the word-count target.

Ports:
- fastclk  in  1  system clock, 50 MHz; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a capture run when in IDLE.
- abort  in  1  one-cycle pulse; terminates run, flushes FIFO and partial word.
- num_words  in  CNT_W  64-bit words to capture in this run; sampled on accepted start.
- sample_in  in  8  parallel sample bits; bit0 maps to sample_in[0].
- sample_tick  out  1  one-cycle pulse on every cycle a byte is captured.
- word_data  out  64  FIFO head word; byte k in [8k+7:8k], byte 0 = first sample.
- word_valid  out  1  FIFO not empty.
- word_ready  in  1  consumer accepts head when word_valid && word_ready.
- fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse on DRAIN->IDLE.
- overflow  out  1  sticky; set when a completed word is dropped.

Behaviour:
- Reset: state IDLE; div counter, byte index, words_left, FIFO pointers all 0.
- Reset values: word_valid=0, fifo_level=0, sample_tick=0, busy=0, done=0, overflow=0, word_data=0.
- States: IDLE, CAPTURE, DRAIN.
- IDLE→CAPTURE: start=1 and num_words!=0.
  - Latch words_left=num_words; clear overflow, byte index and div counter.
  - start with num_words==0 is ignored; stays IDLE, no done pulse.
- start while busy is ignored.
- Tick generation:
  - Div counter runs only in CAPTURE; held at 0 otherwise.
  - Counts 0..DIV-1.
  - sample_tick=1 on the cycle the counter equals DIV-1; the counter wraps to 0 on that cycle.
  - First tick occurs DIV cycles after entering CAPTURE.
- Capture on tick: sample_in is registered into byte[idx], then idx increments mod 8.
- Word completion: tick with idx==7.
  - The full word, including the current byte, is pushed to the FIFO on that edge.
  - words_left decrements on the same edge.
  - If words_left becomes 0, go to DRAIN.
- Latency: completed word appears on word_data/word_valid the cycle after the 8th tick's edge, i.e. visible 1 cycle after the tick pulse.
- FIFO full at push with no pop that cycle:
  - Word is dropped, overflow set.
  - words_left still decrements, so the run length is fixed in samples.
- FIFO full with push and pop in the same cycle: both occur; no overflow; level unchanged.
- Pop: word_valid && word_ready advances the head; word_ready while empty has no effect.
- word_data is defined only while word_valid=1; the bench must not check it otherwise.
- DRAIN: no ticks; wait until the FIFO is empty, including the pop cycle of the last word.
  - On that condition: pulse done for one cycle and go to IDLE.
- abort, any state:
  - Next state IDLE; FIFO emptied; idx=0; words_left=0.
  - No done pulse; overflow preserved.
  - abort has priority over a same-cycle start, tick, push and pop.
- reset has priority over everything.
- overflow clears only on reset or an accepted start.
- words_left and idx do not wrap: a run ends exactly at num_words words.
- A partial word is never emitted.

Test Plan:
- DIV=4, FIFO_DEPTH=4, word_ready=1, start with num_words=1, sample_in = 8'h01..8'h08 on successive ticks.
  - Ticks 4 cycles apart, first 4 cycles after start.
  - word_data=64'h0807060504030201 valid for one cycle.
  - done pulses 1 cycle later; busy drops.
- DIV=4, word_ready=0, num_words=6.
  - fifo_level reaches 4; words 5 and 6 dropped; overflow=1.
  - State stays DRAIN until word_ready=1 pops 4 words, then done.
- Full FIFO with word_ready=1 asserted on the exact push cycle: overflow stays 0, fifo_level stays 4.
- abort after 3 ticks of word 2 with 1 word queued: next cycle word_valid=0, fifo_level=0, busy=0, no done.
  - New start, num_words=1, produces a clean word starting at byte 0.
- start with num_words=0 → busy stays 0, no ticks, no done.
- start asserted during CAPTURE is ignored.
- reset asserted mid-CAPTURE → all outputs return to reset values next cycle; overflow=0.
